// File: rtl/pipelined_addsub.sv
// ============================================================================
//  Module      : pipelined_addsub
//  Description : Pipelined ripple-carry adder/subtractor. A WIDTH-bit
//                operation is split into STAGES slices of CHUNK bits, one
//                slice per pipeline stage, with valid/ready flow control on
//                both sides and one operation per cycle throughput.
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready, a, b, cin, sub   - operand side
//                out_valid/out_ready, sum, cout, ovf - result side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Stage registers. Operands are kept shifted right so that the next slice
  // to be added always sits in the low CHUNK bits. The partial sum is
  // assembled from the top down: each stage shifts it right by CHUNK and
  // inserts its own slice at the top, so after the last stage slice 0 lands
  // in the low bits.
  logic             r_v   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  logic             w_v_n [STAGES];
  logic [WIDTH-1:0] w_a_n [STAGES];
  logic [WIDTH-1:0] w_b_n [STAGES];
  logic [WIDTH-1:0] w_s_n [STAGES];
  logic             w_c_n [STAGES];
  logic             w_ovf_n;
  logic             w_adv;

  // The whole pipeline moves as one: it advances whenever the output slot
  // is empty or being drained this cycle.
  assign w_adv    = !r_v[LAST] || out_ready;
  assign in_ready = w_adv;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [CHUNK:0]   slice;

    if (i == 0) begin : g_first
      // Subtraction is A + ~B + ~cin, so both B and the carry are inverted.
      assign a_in     = a;
      assign b_in     = sub ? ~b : b;
      assign c_in     = cin ^ sub;
      assign w_v_n[i] = in_valid;
    end else begin : g_next
      assign a_in     = r_a[i-1];
      assign b_in     = r_b[i-1];
      assign c_in     = r_c[i-1];
      assign w_v_n[i] = r_v[i-1];
    end

    assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in};

    if (i == 0) begin : g_sum_first
      assign w_s_n[i] = WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK);
    end else begin : g_sum_next
      assign w_s_n[i] = (r_s[i-1] >> CHUNK)
                      | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    assign w_a_n[i] = a_in >> CHUNK;
    assign w_b_n[i] = b_in >> CHUNK;
    assign w_c_n[i] = slice[CHUNK];

    if (i == LAST) begin : g_last
      // Carry into the MSB is recovered from the MSB's own sum bit:
      // s = a ^ b ^ c  =>  c = a ^ b ^ s.
      assign w_ovf_n = (a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ slice[CHUNK-1])
                     ^ slice[CHUNK];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= 1'b0;
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_s[i] <= '0;
        r_c[i] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= w_v_n[i];
        r_a[i] <= w_a_n[i];
        r_b[i] <= w_b_n[i];
        r_s[i] <= w_s_n[i];
        r_c[i] <= w_c_n[i];
      end
      r_ovf <= w_ovf_n;
    end
  end

  assign out_valid = r_v[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
// ============================================================================
//  Module      : tb_pipelined_addsub
//  Description : Self-checking bench for pipelined_addsub (WIDTH=16,
//                STAGES=4). A queue-based arithmetic reference model predicts
//                each accepted operation's result; directed scenarios cover
//                carry ripple, overflow, borrow, throughput, backpressure and
//                reset mid-flight, followed by a randomized stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_addsub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] log_sum[$];
  logic        log_cout[$];
  logic        log_ovf[$];
  int          log_cyc[$];
  int          acc_cyc[$];

  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic        last_acc = 1'b0;
  logic        hold_pending = 1'b0;
  logic [15:0] h_sum;
  logic        h_cout;
  logic        h_ovf;

  // Directed vectors and their expected results.
  logic [15:0] d_a   [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
  logic [15:0] d_b   [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
  logic        d_cin [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        d_sub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] d_sum [5] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFD};
  logic        d_cout[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        d_ovf [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    exp_t        e;
    logic [15:0] bp;
    int          c0;
    int          full;
    int          sres;
    bp   = ms ? ~mb : mb;
    c0   = (mc ^ ms) ? 1 : 0;
    full = int'(ma) + int'(bp) + c0;
    sres = int'($signed(ma)) + int'($signed(bp)) + c0;
    e.s  = full[15:0];
    e.c  = full[16];
    e.o  = (sres > 32767) || (sres < -32768);
    return e;
  endfunction

  // One clock cycle: sample/check at the falling edge, then step past the
  // rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (hold_pending) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum",   32'(sum),       32'(h_sum));
      check("hold_cout",  32'(cout),      32'(h_cout));
      check("hold_ovf",   32'(ovf),       32'(h_ovf));
    end
    check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum",  32'(sum),  32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
        check("ovf",  32'(ovf),  32'(e.o));
      end
      log_sum.push_back(sum);
      log_cout.push_back(cout);
      log_ovf.push_back(ovf);
      log_cyc.push_back(cyc);
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      exp_q.push_back(model(a, b, cin, sub));
      acc_cyc.push_back(cyc);
    end
    hold_pending = out_valid && !out_ready && !rst;
    h_sum  = sum;
    h_cout = cout;
    h_ovf  = ovf;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end
    cyc++;
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int abase;
    int sent;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state.
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Directed arithmetic corner cases.
    base = log_sum.size();
    for (int j = 0; j < 5; j++) send(d_a[j], d_b[j], d_cin[j], d_sub[j]);
    in_valid = 1'b0;
    drain();
    check("dir_count", 32'(log_sum.size() - base), 32'd5);
    if (log_sum.size() - base == 5) begin
      for (int j = 0; j < 5; j++) begin
        check($sformatf("dir%0d_sum", j),  32'(log_sum[base+j]),  32'(d_sum[j]));
        check($sformatf("dir%0d_cout", j), 32'(log_cout[base+j]), 32'(d_cout[j]));
        check($sformatf("dir%0d_ovf", j),  32'(log_ovf[base+j]),  32'(d_ovf[j]));
      end
    end

    // Back-to-back throughput and latency.
    base  = log_cyc.size();
    abase = acc_cyc.size();
    for (int j = 0; j < 8; j++) send(16'(j), 16'(16'h1000 * j), 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    check("tput_count", 32'(log_cyc.size() - base), 32'd8);
    if (log_cyc.size() - base == 8) begin
      for (int j = 0; j < 8; j++)
        check($sformatf("tput_lat%0d", j), 32'(log_cyc[base+j]),
              32'(acc_cyc[abase] + STAGES + j));
    end

    // Backpressure: consumer stalls for cycles 5..8 of the stream.
    base = log_sum.size();
    sent = 0;
    for (int t = 0; t < 60 && (sent < 6 || exp_q.size() != 0); t++) begin
      out_ready = !(t >= 5 && t <= 8);
      if (sent < 6) begin
        in_valid = 1'b1;
        a = 16'(16'h0100 * sent + 3);
        b = 16'($urandom);
        cin = 1'(sent); sub = 1'(sent >> 1);
      end else begin
        in_valid = 1'b0;
      end
      if (t == 6) begin
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready",  32'(in_ready),  32'd0);
      end
      cycle();
      if (last_acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent",      32'(sent), 32'd6);
    check("bp_delivered", 32'(log_sum.size() - base), 32'd6);
    check("bp_pending",   32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight.
    for (int j = 0; j < 3; j++) send(16'(16'h1111 * (j + 1)), 16'h0F0F, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    base = log_cyc.size();
    for (int k = 0; k < 6; k++) begin
      check("post_rst_idle", 32'(out_valid), 32'd0);
      cycle();
    end
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain();
    check("post_rst_count", 32'(log_cyc.size() - base), 32'd1);
    if (log_cyc.size() - base == 1) begin
      check("post_rst_lat", 32'(log_cyc[base]), 32'(acc_cyc[acc_cyc.size()-1] + STAGES));
      check("post_rst_sum", 32'(log_sum[base]), 32'h5556);
    end

    // Randomized stream with random backpressure.
    base = log_sum.size();
    sent = 0;
    for (int k = 0; k < 80; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check("rand_delivered", 32'(log_sum.size() - base), 32'(sent));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
